// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter
//   Two-master, one-slave Wishbone arbiter. Master 0 is the CPU data side and
//   master 1 is the instruction side. A master keeps the bus for its whole cyc
//   window. When both masters request at once, the one not granted last wins.
//   There is always at least one idle cycle between two ownerships.
//
// Optional feature (compile-time macro WB_ARB_TIMEOUT_EN):
//   A watchdog that pulses the owner's err for one cycle after TIMEOUT
//   stalled cycles without ack. When the macro is undefined, m0_err_o and
//   m1_err_o are tied to 0.
//
// Parameters:
//   AW      address width
//   DW      data width (sel is DW/8 bits)
//   TIMEOUT stalled cycles before err (watchdog only), 2..65535
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   m0_*_i / m0_*_o          master 0 request in, response out
//   m1_*_i / m1_*_o          master 1 request in, response out
//   s_*_o / s_data_i/s_ack_i slave request out, slave response in
//   grant_o                  one-hot owner (01 = m0, 10 = m1, 00 = idle)

module wishbone_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   m0_addr_i,
  input  logic [DW-1:0]   m0_data_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_stb_i,
  input  logic            m0_cyc_i,
  output logic [DW-1:0]   m0_data_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_data_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_stb_i,
  input  logic            m1_cyc_i,
  output logic [DW-1:0]   m1_data_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_data_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  input  logic [DW-1:0]   s_data_i,
  input  logic            s_ack_i,
  output logic [1:0]      grant_o
);

  // The state encoding is also the one-hot grant, so grant_o is a plain register copy.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state, state_next;
  logic   last;

  // Reject an out-of-range watchdog length at elaboration.
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wishbone_arbiter: TIMEOUT must be in 2..65535");
  end

  // State register. 'last' records the master granted most recently. It resets
  // to 1 so that master 0 wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == OWN0) last <= 1'b0;
      if (state == IDLE && state_next == OWN1) last <= 1'b1;
    end
  end

  // Next-state logic. The current owner is never preempted. It keeps the bus
  // until it drops cyc.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_next = last ? OWN0 : OWN1;
        else if (m0_cyc_i)        state_next = OWN0;
        else if (m1_cyc_i)        state_next = OWN1;
      end
      OWN0:    if (!m0_cyc_i) state_next = IDLE;
      OWN1:    if (!m1_cyc_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output routing depends only on the registered state. In IDLE there is no
  // path from any master's cyc to the slave, and a stray slave ack is dropped.
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    unique case (state)
      OWN0: begin
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_we_o    = m0_we_i;
        s_sel_o   = m0_sel_i;
        s_stb_o   = m0_stb_i;
        s_cyc_o   = m0_cyc_i;
        m0_data_o = s_data_i;
        m0_ack_o  = s_ack_i;
      end
      OWN1: begin
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_we_o    = m1_we_i;
        s_sel_o   = m1_sel_i;
        s_stb_o   = m1_stb_i;
        s_cyc_o   = m1_cyc_i;
        m1_data_o = s_data_i;
        m1_ack_o  = s_ack_i;
      end
      default: ;
    endcase
  end

  assign grant_o = state;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_TERM = CW'(TIMEOUT - 1);

  logic [CW-1:0] wd_count;
  logic          wd_hit;

  // A late ack in the terminal cycle takes priority over err.
  assign wd_hit = (state != IDLE) && s_stb_o && !s_ack_i && (wd_count == WD_TERM);

  // The watchdog counts stalled strobe cycles. It restarts on ack, on an idle
  // strobe, on an ownership change, and after each err pulse, so err repeats
  // every TIMEOUT cycles while the slave stays silent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_count <= '0;
    end else if (state_next != state || !s_stb_o || s_ack_i || wd_hit) begin
      wd_count <= '0;
    end else begin
      wd_count <= wd_count + CW'(1);
    end
  end

  assign m0_err_o = wd_hit && (state == OWN0);
  assign m1_err_o = wd_hit && (state == OWN1);
`else
  assign m0_err_o = 1'b0;
  assign m1_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_arbiter.sv
// tb_wishbone_arbiter
//   Directed bench for wishbone_arbiter. It keeps an ownership and
//   stall-count model that is updated on every rising edge, and it compares
//   every DUT output against that model on each falling edge. Hand-computed
//   literal checks along the scenario pin the model itself. The bench runs
//   with TIMEOUT = 4. It follows WB_ARB_TIMEOUT_EN in the same way as the RTL.

module tb_wishbone_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  int num_checks = 0;
  int num_errors = 0;

  int mdl_owner;
  int mdl_last;
  int mdl_stall;
  int mdl_next;

  wishbone_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value. Every failure prints a single FAIL line.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Move to the next cycle, then drive the controls {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}.
  task automatic applyStimulus(input logic [4:0] ctl);
    @(posedge clk);
    #1;
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = ctl;
  endtask

  function automatic logic cyc_of(input int i);
    return (i == 0) ? m0_cyc_i : m1_cyc_i;
  endfunction

  function automatic logic stb_of(input int i);
    return (i == 0) ? m0_stb_i : m1_stb_i;
  endfunction

  // Model: owner is -1 when idle. A tie goes to the master not served last.
  // The owner keeps the bus until it drops cyc. mdl_stall counts consecutive
  // strobe cycles without ack in one ownership.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_owner = -1;
      mdl_last  = 1;
      mdl_stall = 0;
    end else begin
      mdl_next = mdl_owner;
      if (mdl_owner < 0) begin
        if (m0_cyc_i && m1_cyc_i) mdl_next = 1 - mdl_last;
        else if (m0_cyc_i)        mdl_next = 0;
        else if (m1_cyc_i)        mdl_next = 1;
        if (mdl_next >= 0) mdl_last = mdl_next;
      end else if (!cyc_of(mdl_owner)) begin
        mdl_next = -1;
      end
      if (mdl_next != mdl_owner || mdl_owner < 0 || !stb_of(mdl_owner) || s_ack_i)
        mdl_stall = 0;
      else
        mdl_stall = mdl_stall + 1;
      mdl_owner = mdl_next;
    end
  end

  // On every falling edge, check every DUT output against the model.
  always @(negedge clk) begin : compare
    logic [31:0] e_addr, e_data, e_d0, e_d1;
    logic [3:0]  e_sel;
    logic        e_we, e_stb, e_cyc, e_a0, e_a1, e_err;
    logic [1:0]  e_grant;
    e_addr = '0; e_data = '0; e_sel = '0; e_we = 1'b0; e_stb = 1'b0; e_cyc = 1'b0;
    e_d0 = '0; e_d1 = '0; e_a0 = 1'b0; e_a1 = 1'b0; e_err = 1'b0;
    e_grant = (mdl_owner < 0) ? 2'b00 : 2'(1 << mdl_owner);
    if (mdl_owner == 0) begin
      e_addr = m0_addr_i; e_data = m0_data_i; e_sel = m0_sel_i; e_we = m0_we_i;
      e_stb = m0_stb_i; e_cyc = m0_cyc_i; e_d0 = s_data_i; e_a0 = s_ack_i;
    end else if (mdl_owner == 1) begin
      e_addr = m1_addr_i; e_data = m1_data_i; e_sel = m1_sel_i; e_we = m1_we_i;
      e_stb = m1_stb_i; e_cyc = m1_cyc_i; e_d1 = s_data_i; e_a1 = s_ack_i;
    end
`ifdef WB_ARB_TIMEOUT_EN
    e_err = (mdl_owner >= 0) && e_stb && !s_ack_i && ((mdl_stall % TMO) == TMO - 1);
`endif
    checkOutput("grant",    32'(grant_o),   32'(e_grant));
    checkOutput("s_cyc",    32'(s_cyc_o),   32'(e_cyc));
    checkOutput("s_stb",    32'(s_stb_o),   32'(e_stb));
    checkOutput("s_we",     32'(s_we_o),    32'(e_we));
    checkOutput("s_addr",   s_addr_o,       e_addr);
    checkOutput("s_data",   s_data_o,       e_data);
    checkOutput("s_sel",    32'(s_sel_o),   32'(e_sel));
    checkOutput("m0_data",  m0_data_o,      e_d0);
    checkOutput("m1_data",  m1_data_o,      e_d1);
    checkOutput("m0_ack",   32'(m0_ack_o),  32'(e_a0));
    checkOutput("m1_ack",   32'(m1_ack_o),  32'(e_a1));
    checkOutput("m0_err",   32'(m0_err_o),  32'(e_err && mdl_owner == 0));
    checkOutput("m1_err",   32'(m1_err_o),  32'(e_err && mdl_owner == 1));
  end

  // Directed scenario with hand-computed literal expectations.
  initial begin
    rst = 1'b0;
    m0_addr_i = 32'h0000_2000; m0_data_i = 32'hA5A5_0001; m0_we_i = 1'b1; m0_sel_i = 4'h3;
    m1_addr_i = 32'h0000_0000; m1_data_i = 32'h5A5A_0002; m1_we_i = 1'b0; m1_sel_i = 4'hF;
    s_data_i  = 32'h1234_5678;
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = 5'b11110;

    // Both masters request while reset is held.
    applyStimulus(5'b11110);
    applyStimulus(5'b11110);
    #1;
    checkOutput("reset_grant", 32'(grant_o), 32'h0);
    checkOutput("reset_s_cyc", 32'(s_cyc_o), 32'h0);
    rst = 1'b1;
    applyStimulus(5'b11110);
    #1;
    checkOutput("release_grant", 32'(grant_o), 32'h1);

    // Single master: m1 reads 0x100, and the slave acks on the 2nd cycle while cyc drops.
    applyStimulus(5'b00000);
    m1_addr_i = 32'h0000_0100;
    applyStimulus(5'b00111);
    #1;
    checkOutput("idle_ack_m0", 32'(m0_ack_o), 32'h0);
    checkOutput("idle_ack_m1", 32'(m1_ack_o), 32'h0);
    applyStimulus(5'b00110);
    #1;
    checkOutput("m1_addr", s_addr_o, 32'h0000_0100);
    applyStimulus(5'b00001);
    s_data_i = 32'hDEAD_BEEF;
    #1;
    checkOutput("m1_read_data", m1_data_o, 32'hDEAD_BEEF);
    checkOutput("m1_read_ack",  32'(m1_ack_o), 32'h1);
    checkOutput("m1_read_m0ack", 32'(m0_ack_o), 32'h0);

    // Contention: grants alternate, with one idle cycle between ownerships.
    applyStimulus(5'b11110);
    s_data_i = 32'h0BAD_F00D;
    #1;
    checkOutput("rr_first_idle", 32'(grant_o), 32'h0);
    for (int r = 0; r < 4; r++) begin
      applyStimulus(5'b11111);
      #1;
      checkOutput("rr_grant", 32'(grant_o), (r % 2 == 0) ? 32'h1 : 32'h2);
      applyStimulus((r % 2 == 0) ? 5'b00110 : 5'b11000);
      applyStimulus(5'b11110);
      #1;
      checkOutput("rr_idle", 32'(grant_o), 32'h0);
    end

    // Master 0 alone is granted again each time.
    for (int r = 0; r < 3; r++) begin
      applyStimulus(5'b11001);
      #1;
      checkOutput("m0_regrant", 32'(grant_o), 32'h1);
      applyStimulus(5'b00000);
      applyStimulus(5'b11000);
    end

    // No preemption: m0 holds the bus through a 10-cycle ack delay.
    applyStimulus(5'b11110);
    #1;
    checkOutput("nopre_hold", 32'(grant_o), 32'h1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(5'b11110);
      #1;
      checkOutput("nopre_hold", 32'(grant_o), 32'h1);
    end
    applyStimulus(5'b11111);
    #1;
    checkOutput("nopre_ack", 32'(m0_ack_o), 32'h1);
    applyStimulus(5'b00110);
    #1;
    checkOutput("nopre_drop", 32'(grant_o), 32'h1);
    applyStimulus(5'b00110);
    #1;
    checkOutput("nopre_idle", 32'(grant_o), 32'h0);
    applyStimulus(5'b00110);
    #1;
    checkOutput("nopre_m1", 32'(grant_o), 32'h2);

    // Reset during OWN1 with stb high drops the slave cyc and stb at once.
    rst = 1'b0;
    #1;
    checkOutput("midreset_s_cyc", 32'(s_cyc_o), 32'h0);
    checkOutput("midreset_s_stb", 32'(s_stb_o), 32'h0);
    checkOutput("midreset_grant", 32'(grant_o), 32'h0);
    applyStimulus(5'b11110);
    rst = 1'b1;
    applyStimulus(5'b11110);
    #1;
    checkOutput("post_reset_tie", 32'(grant_o), 32'h1);

    // Watchdog: the slave never acks, and m0 keeps stb high.
    applyStimulus(5'b00000);
    applyStimulus(5'b11000);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(5'b11000);
      #1;
`ifdef WB_ARB_TIMEOUT_EN
      checkOutput("wd_err", 32'(m0_err_o), (k % 4 == 0) ? 32'h1 : 32'h0);
`else
      checkOutput("wd_err", 32'(m0_err_o), 32'h0);
`endif
    end
    // A late ack in the terminal cycle wins over err.
    applyStimulus(5'b11001);
    #1;
    checkOutput("wd_late_ack", 32'(m0_ack_o), 32'h1);
    checkOutput("wd_late_err", 32'(m0_err_o), 32'h0);
    applyStimulus(5'b00000);
    applyStimulus(5'b00000);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
